usrt_tx_shift_p: RTL and testbench

USRT_TX_SHIFT_P -- requirements
Module: usrt_tx_shift_p

---
 rtl/usrt_tx_shift_p.sv | 181 ++++++++++++++++++
 tb/tb_usrt_tx_shift_p.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_tx_shift_p.sv
// usrt_tx_shift_p: serial frame transmitter sending start, LSB-first data, optional parity and 1-2 stop bits.
// Define USRT_TX_PARITY_EN to compile in parity generation and the PARITY state.
module usrt_tx_shift_p #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_WIDTH = 14
) (
  input  logic                  i_Pclk,
  input  logic                  i_Presetn,
  input  logic [BAUD_WIDTH-1:0] i_Baud,
  input  logic                  i_Enable,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Parity_En,
  input  logic                  i_Parity_Odd,
  input  logic                  i_Two_Stop,
  output logic                  o_Tx_Serial,
  output logic                  o_Pready,
  output logic                  o_Busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [BAUD_WIDTH-1:0] BAUD_ONE = BAUD_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_WIDTH-1:0] cnt_q, cnt_d;
  logic [BAUD_WIDTH-1:0] baud_m1_q, baud_m1_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  pready_q, pready_d;
  logic                  bit_done;

`ifdef USRT_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_parity;
  assign unused_parity = i_Parity_En ^ i_Parity_Odd;
`endif

  // cnt_q counts down the remaining cycles of the current bit; zero marks its last cycle.
  assign bit_done = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    baud_m1_d  = baud_m1_q;
    idx_d      = idx_q;
    data_d     = data_q;
    two_stop_d = two_stop_q;
    pready_d   = 1'b0;
`ifdef USRT_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = bit_done ? baud_m1_q : cnt_q - BAUD_ONE;
    end

    case (state_q)
      IDLE: begin
        if (i_Enable) begin
          state_d    = START;
          baud_m1_d  = (i_Baud == '0) ? '0 : i_Baud - BAUD_ONE;
          cnt_d      = baud_m1_d;
          idx_d      = '0;
          data_d     = i_Data;
          two_stop_d = i_Two_Stop;
`ifdef USRT_TX_PARITY_EN
          par_en_d   = i_Parity_En;
          par_bit_d  = (^i_Data) ^ i_Parity_Odd;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
`ifdef USRT_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP1;
`else
            state_d = STOP1;
`endif
          end else begin
            idx_d  = idx_q + IDX_ONE;
            data_d = data_q >> 1;
          end
        end
      end
`ifdef USRT_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP1;
        end
      end
`endif
      STOP1: begin
        if (bit_done) begin
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            state_d  = IDLE;
            pready_d = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bit_done) begin
          state_d  = IDLE;
          pready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so it changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[0];
`ifdef USRT_TX_PARITY_EN
      PARITY:  tx_d = par_bit_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      baud_m1_q  <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      pready_q   <= 1'b0;
`ifdef USRT_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      baud_m1_q  <= baud_m1_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      pready_q   <= pready_d;
`ifdef USRT_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign o_Tx_Serial = tx_q;
  assign o_Busy      = busy_q;
  assign o_Pready    = pready_q;

endmodule

// File: tb/tb_usrt_tx_shift_p.sv
// Self-checking bench for usrt_tx_shift_p: vector table, corner-case sequences and random frames
// checked against a frame-level model of the serial line.
module tb_usrt_tx_shift_p;

  typedef struct {
    logic [7:0]  data;
    logic [13:0] baud;
    logic        pe;
    logic        po;
    logic        ts;
    logic [11:0] expBits;
    int          expN;
    int          expB;
  } vec_t;

`ifdef USRT_TX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [13:0] baud = '0;
  logic        en = 1'b0;
  logic [7:0]  data = '0;
  logic        parEn = 1'b0;
  logic        parOdd = 1'b0;
  logic        twoStop = 1'b0;
  logic        tx, pready, busy;

  logic [13:0] baud5 = '0;
  logic        en5 = 1'b0;
  logic [4:0]  data5 = '0;
  logic        tieOff = 1'b0;
  logic        tx5, pready5, busy5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastPreadyCyc = 0;

  usrt_tx_shift_p #(.DATA_WIDTH(8), .BAUD_WIDTH(14)) dut (
    .i_Pclk(clk), .i_Presetn(rstN), .i_Baud(baud), .i_Enable(en), .i_Data(data),
    .i_Parity_En(parEn), .i_Parity_Odd(parOdd), .i_Two_Stop(twoStop),
    .o_Tx_Serial(tx), .o_Pready(pready), .o_Busy(busy)
  );

  usrt_tx_shift_p #(.DATA_WIDTH(5), .BAUD_WIDTH(14)) dut5 (
    .i_Pclk(clk), .i_Presetn(rstN), .i_Baud(baud5), .i_Enable(en5), .i_Data(data5),
    .i_Parity_En(tieOff), .i_Parity_Odd(tieOff), .i_Two_Stop(tieOff),
    .o_Tx_Serial(tx5), .o_Pready(pready5), .o_Busy(busy5)
  );

  // Free-running clock and cycle counter used to time o_Pready pulses.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected line bits of one frame, in transmission order.
  function automatic void modelFrame(input logic [7:0] d, input logic pe, input logic po,
                                     input logic ts, output logic [11:0] bits, output int n);
    logic parityBit;
    parityBit = (^d) ^ po;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i]; n++;
    end
    if (pe && PARITY_BUILT) begin
      bits[n] = parityBit; n++;
    end
    bits[n] = 1'b1; n++;
    if (ts) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  // Present a frame request; called at a falling edge so it is accepted at the next rising edge.
  task automatic applyStimulus(input logic [7:0] d, input logic [13:0] bd, input logic pe,
                               input logic po, input logic ts);
    data = d; baud = bd; parEn = pe; parOdd = po; twoStop = ts; en = 1'b1;
  endtask

  // Follow one frame from its accept edge to the o_Pready cycle, scrambling inputs mid-frame.
  task automatic checkFrame(input string name, input logic [11:0] bits, input int n, input int b);
    int total, txBad, busyBad, preadyAt, preadyCount;
    logic expTx, expBusy;
    total = n * b;
    txBad = -1; busyBad = -1; preadyAt = -1; preadyCount = 0;
    @(posedge clk);
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      expTx   = (k < total) ? bits[k / b] : 1'b1;
      expBusy = (k < total);
      if (tx !== expTx && txBad < 0) txBad = k;
      if (busy !== expBusy && busyBad < 0) busyBad = k;
      if (pready === 1'b1) begin
        preadyCount++;
        if (preadyAt < 0) begin
          preadyAt = k;
          lastPreadyCyc = cyc;
        end
      end
      if (k < total) begin
        en = 1'($urandom_range(0, 1));
        data = 8'($urandom);
        baud = 14'($urandom);
        parEn = 1'($urandom_range(0, 1));
        parOdd = 1'($urandom_range(0, 1));
        twoStop = 1'($urandom_range(0, 1));
      end else begin
        en = 1'b0;
      end
    end
    checkOutput({name, " tx first bad cycle"}, txBad, -1);
    checkOutput({name, " busy first bad cycle"}, busyBad, -1);
    checkOutput({name, " pready cycle"}, preadyAt, total);
    checkOutput({name, " pready pulse count"}, preadyCount, 1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [11:0] bits;
    logic [6:0]  obs5;
    logic [7:0]  rd;
    logic [13:0] rb;
    logic        rpe, rpo, rts;
    int          n, p1, quiet, p5;

    vecs[0] = '{8'h53, 14'd87, 1'b0, 1'b0, 1'b0, 12'h2A6, 10, 87};
    vecs[1] = '{8'h53, 14'd87, 1'b1, 1'b0, 1'b0, PARITY_BUILT ? 12'h4A6 : 12'h2A6,
                PARITY_BUILT ? 11 : 10, 87};
    vecs[2] = '{8'h53, 14'd87, 1'b1, 1'b1, 1'b0, PARITY_BUILT ? 12'h6A6 : 12'h2A6,
                PARITY_BUILT ? 11 : 10, 87};
    vecs[3] = '{8'hFF, 14'd4, 1'b0, 1'b0, 1'b1, 12'h7FE, 11, 4};
    vecs[4] = '{8'h00, 14'd0, 1'b0, 1'b0, 1'b0, 12'h200, 10, 1};
    vecs[5] = '{8'hA5, 14'd3, 1'b1, 1'b1, 1'b1, PARITY_BUILT ? 12'hF4A : 12'h74A,
                PARITY_BUILT ? 12 : 11, 3};

    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", int'(tx), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset pready", int'(pready), 0);
    rstN = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || pready !== 1'b0) quiet++;
    end
    checkOutput("idle without enable activity", quiet, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge clk);
      applyStimulus(vecs[i].data, vecs[i].baud, vecs[i].pe, vecs[i].po, vecs[i].ts);
      checkFrame($sformatf("vec%0d", i), vecs[i].expBits, vecs[i].expN, vecs[i].expB);
    end

    $display("[TB] back-to-back frames");
    repeat (2) @(negedge clk);
    applyStimulus(8'hA5, 14'd2, 1'b0, 1'b0, 1'b0);
    modelFrame(8'hA5, 1'b0, 1'b0, 1'b0, bits, n);
    checkFrame("b2b first", bits, n, 2);
    p1 = lastPreadyCyc;
    applyStimulus(8'h3C, 14'd2, 1'b0, 1'b0, 1'b0);
    modelFrame(8'h3C, 1'b0, 1'b0, 1'b0, bits, n);
    checkFrame("b2b second", bits, n, 2);
    checkOutput("b2b pready spacing", lastPreadyCyc - p1, 21);

    $display("[TB] reset during 4th data bit");
    repeat (2) @(negedge clk);
    applyStimulus(8'h53, 14'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    repeat (18) @(negedge clk);
    en = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("midreset tx", int'(tx), 1);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset pready", int'(pready), 0);
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || pready !== 1'b0) quiet++;
    end
    rstN = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || pready !== 1'b0) quiet++;
    end
    checkOutput("after midreset activity", quiet, 0);

    $display("[TB] five-bit data, zero baud");
    @(negedge clk);
    data5 = 5'h15; baud5 = 14'd0; en5 = 1'b1;
    @(posedge clk);
    obs5 = '0; p5 = -1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) en5 = 1'b0;
      if (k < 7) obs5[k] = tx5;
      if (pready5 === 1'b1 && p5 < 0) p5 = k;
    end
    checkOutput("dw5 line bits", int'(obs5), 32'h6A);
    checkOutput("dw5 pready cycle", p5, 7);

    $display("[TB] random frames");
    for (int r = 0; r < 15; r++) begin
      rd = 8'($urandom);
      rb = 14'($urandom_range(0, 5));
      rpe = 1'($urandom_range(0, 1));
      rpo = 1'($urandom_range(0, 1));
      rts = 1'($urandom_range(0, 1));
      modelFrame(rd, rpe, rpo, rts, bits, n);
      repeat (r % 2) @(negedge clk);
      applyStimulus(rd, rb, rpe, rpo, rts);
      checkFrame($sformatf("rand%0d", r), bits, n, (rb == 0) ? 1 : int'(rb));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
